// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one Booth multiplier between four requesters.
// Define ARB_WATCHDOG_EN to add a WAIT timeout that responds with a zero product and timeout_err.
module booth_mult_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_mplier,
    input  logic [N_REQ*WIDTH-1:0]   req_mpcand,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_mplier,
    output logic [WIDTH-1:0]         mul_mpcand,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     busy,
`ifdef ARB_WATCHDOG_EN
    output logic                     timeout_err,
`endif
    output logic [1:0]               grant_id
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           grant_id_q, grant_id_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mpcand_q, mpcand_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                 mul_start_q, mul_start_d;
    logic                 busy_q, busy_d;
    logic                 first_wait_q, first_wait_d;
    logic [1:0]           winner;
    logic [1:0]           idx;
`ifdef ARB_WATCHDOG_EN
    localparam logic [4:0] WD_LAST = 5'd30;
    logic [4:0]           wd_cnt_q, wd_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // Descending search so the smallest offset from the last grant is assigned last and wins.
    always_comb begin
        winner = grant_id_q;
        idx    = grant_id_q;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = grant_id_q + 2'(k);
            if (req_valid[idx]) winner = idx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        mplier_d     = mplier_q;
        mpcand_d     = mpcand_q;
        product_d    = product_q;
        rsp_valid_d  = '0;
        mul_start_d  = 1'b0;
        first_wait_d = 1'b0;
        req_ready    = '0;
`ifdef ARB_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // req_ready is a same-cycle handshake so a held request transfers on this edge.
                if (|req_valid) begin
                    req_ready[winner] = 1'b1;
                    grant_id_d        = winner;
                    mplier_d          = req_mplier[int'(winner)*WIDTH +: WIDTH];
                    mpcand_d          = req_mpcand[int'(winner)*WIDTH +: WIDTH];
                    mul_start_d       = 1'b1;
                    state_d           = LAUNCH;
                end
            end
            LAUNCH: begin
                first_wait_d = 1'b1;
                state_d      = WAIT;
`ifdef ARB_WATCHDOG_EN
                wd_cnt_d     = '0;
`endif
            end
            WAIT: begin
                // Done is still high from the previous operation during the first WAIT cycle.
                if (!first_wait_q && mul_done) begin
                    product_d              = mul_product;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                = RESP;
                end
`ifdef ARB_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    product_d              = '0;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    timeout_d              = 1'b1;
                    state_d                = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 5'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: asynchronous active-low reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            grant_id_q   <= 2'd3;
            mplier_q     <= '0;
            mpcand_q     <= '0;
            product_q    <= '0;
            rsp_valid_q  <= '0;
            mul_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            first_wait_q <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            mplier_q     <= mplier_d;
            mpcand_q     <= mpcand_d;
            product_q    <= product_d;
            rsp_valid_q  <= rsp_valid_d;
            mul_start_q  <= mul_start_d;
            busy_q       <= busy_d;
            first_wait_q <= first_wait_d;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = product_q;
    assign mul_start   = mul_start_q;
    assign mul_mplier  = mplier_q;
    assign mul_mpcand  = mpcand_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
`ifdef ARB_WATCHDOG_EN
    assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized bench for booth_mult_arbiter with a behavioural multiplier and round-robin/latency model.
// Define ARB_WATCHDOG_EN to also exercise the WAIT timeout.
module tb_booth_mult_arbiter;

    localparam int WIDTH   = 16;
    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 9;
    localparam int LAT     = MUL_LAT + 3;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic [3:0]        vld = '0;
    logic [15:0]       op_a [4];
    logic [15:0]       op_b [4];
    logic [63:0]       req_mplier, req_mpcand;
    logic [3:0]        req_ready, rsp_valid;
    logic [31:0]       rsp_product;
    logic              mul_start, busy;
    logic [15:0]       mul_mplier, mul_mpcand;
    logic              mul_done;
    logic [31:0]       model_prod = '0;
    logic              model_done = 1'b0;
    int                model_cnt = 0;
    logic              stale_hold = 1'b0;
    logic              kill_done = 1'b0;
    logic [1:0]        grant_id;
`ifdef ARB_WATCHDOG_EN
    logic              timeout_err;
`endif

    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    logic [1:0]        m_last = 2'd3;
    logic [31:0]       got_p;

    booth_mult_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .req_valid   (vld),
        .req_mplier  (req_mplier),
        .req_mpcand  (req_mpcand),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .mul_start   (mul_start),
        .mul_mplier  (mul_mplier),
        .mul_mpcand  (mul_mpcand),
        .mul_done    (mul_done),
        .mul_product (model_prod),
        .busy        (busy),
`ifdef ARB_WATCHDOG_EN
        .timeout_err (timeout_err),
`endif
        .grant_id    (grant_id)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    always_comb begin
        req_mplier = '0;
        req_mpcand = '0;
        for (int i = 0; i < 4; i++) begin
            req_mplier[i*16 +: 16] = op_a[i];
            req_mpcand[i*16 +: 16] = op_b[i];
        end
    end

    function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            int p;
            p = (int'(last) + k) % 4;
            if (mask[p]) return 2'(p);
        end
        return last;
    endfunction

    // Radix-4 multiplier: load on start, 8 iterations, Done stays high until the next start.
    assign mul_done = !kill_done && (model_done || stale_hold);
    always @(posedge Clock) begin
        if (mul_start) begin
            model_done <= 1'b0;
            model_cnt  <= MUL_LAT;
        end else if (model_cnt == 1) begin
            model_cnt  <= 0;
            model_done <= 1'b1;
            model_prod <= smul(mul_mplier, mul_mpcand);
        end else if (model_cnt > 1) begin
            model_cnt  <= model_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset_n) begin
            check("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
            check("rsp_onehot", 64'($onehot0(rsp_valid)), 64'd1);
            check("ready_rsp_overlap", 64'(req_ready & rsp_valid), 64'd0);
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_start", mul_start, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_product", rsp_product, 0);
        check("rst_mplier", mul_mplier, 0);
        check("rst_mpcand", mul_mpcand, 0);
        check("rst_grant", grant_id, 3);
`ifdef ARB_WATCHDOG_EN
        check("rst_timeout", timeout_err, 0);
`endif
    endtask

    // Called just after a rising edge with the arbiter idle; serves every requester in mask.
    task automatic serve(input logic [3:0] mask, input bit stale, input bit rnd_new,
                         input int exp_lat, input bit exp_to, output logic [31:0] prod);
        logic [3:0]  pending;
        logic [1:0]  id;
        logic [31:0] exp_p;
        int          t0, t_start, n_start, w, j;
        bit          got_rsp;
        pending = mask;
        vld     = mask;
        prod    = '0;
        while (pending != 0) begin
            id    = rr_pick(m_last, pending);
            exp_p = exp_to ? 32'd0 : smul(op_a[id], op_b[id]);
            w     = 0;
            @(negedge Clock);
            while (req_ready == 0 && w < 40) begin
                @(negedge Clock);
                w++;
            end
            check("accept_gap", w, 0);
            check("ready", req_ready, 4'b0001 << id);
            check("idle_busy", busy, 0);
            t0      = cyc;
            m_last  = id;
            pending[id] = 1'b0;
            n_start = 0;
            t_start = -1;
            got_rsp = 0;
            while (!got_rsp && cyc - t0 < 80) begin
                @(posedge Clock);
                #1;
                if (cyc == t0 + 1) begin
                    vld[id] = 1'b0;
                    if (stale) stale_hold = 1'b1;
                end
                if (cyc == t0 + 3) stale_hold = 1'b0;
                if (rnd_new && $urandom_range(0, 7) == 0) begin
                    j = $urandom_range(0, 3);
                    if (!pending[j] && j != int'(id)) begin
                        op_a[j]    = 16'($urandom);
                        op_b[j]    = 16'($urandom);
                        vld[j]     = 1'b1;
                        pending[j] = 1'b1;
                    end
                end
                @(negedge Clock);
                if (mul_start) begin
                    n_start++;
                    t_start = cyc;
                end
                if (rsp_valid != 0) begin
                    got_rsp = 1;
                end else begin
                    check("wait_busy", busy, 1);
                    check("no_ready_busy", req_ready, 0);
                end
            end
            check("latency", cyc - t0, exp_lat);
            check("rsp_id", rsp_valid, 4'b0001 << id);
            check("rsp_busy", busy, 1);
            check("grant_id", grant_id, id);
            check("product", rsp_product, exp_p);
            check("start_count", n_start, 1);
            check("start_cycle", t_start - t0, 1);
`ifdef ARB_WATCHDOG_EN
            check("timeout_err", timeout_err, exp_to);
`endif
            prod = rsp_product;
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_reset_vals();
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // Contention from reset, then a fifth grant that wraps back to requester 0.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
        end
        serve(4'b1111, 0, 0, LAT, 0, got_p);
        op_a[0] = 16'd3;
        op_b[0] = 16'hFFFB;
        serve(4'b0001, 0, 0, LAT, 0, got_p);
        check("single_m15", got_p, 32'hFFFF_FFF1);

        op_a[1] = 16'h8000;
        op_b[1] = 16'h8000;
        serve(4'b0010, 0, 0, LAT, 0, got_p);
        check("ext_min_min", got_p, 32'h4000_0000);
        op_a[2] = 16'h7FFF;
        op_b[2] = 16'h8000;
        serve(4'b0100, 0, 0, LAT, 0, got_p);
        check("ext_max_min", got_p, 32'hC000_8000);

        op_a[3] = 16'h0123;
        op_b[3] = 16'hFF00;
        serve(4'b1000, 1, 0, LAT, 0, got_p);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = 16'($urandom);
                op_b[i] = 16'($urandom);
            end
            serve(4'($urandom_range(1, 15)), 0, 1, LAT, 0, got_p);
        end

        // Reset in the middle of WAIT aborts the operation without a response.
        op_a[2] = 16'h1234;
        op_b[2] = 16'h5678;
        vld = 4'b0100;
        @(negedge Clock);
        check("pre_rst_ready", req_ready, 4'b0001 << rr_pick(m_last, 4'b0100));
        @(posedge Clock);
        #1;
        vld = '0;
        repeat (4) @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        @(negedge Clock);
        check_reset_vals();
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        m_last = 2'd3;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clock);
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        @(posedge Clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
        end
        serve(4'b1111, 0, 0, LAT, 0, got_p);

`ifdef ARB_WATCHDOG_EN
        kill_done = 1'b1;
        op_a[1] = 16'h0055;
        op_b[1] = 16'h0AA0;
        serve(4'b0010, 0, 0, 33, 1, got_p);
        check("wd_product", got_p, 32'd0);
        kill_done = 1'b0;
        repeat (12) @(posedge Clock);
        #1;
        serve(4'b0100, 0, 0, LAT, 0, got_p);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand width; product width is 2*WIDTH.
REQ-002 Parameter N_REQ, default 4: number of requesters; fixed at 4 in this revision.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester request; held until accepted.
REQ-006 req_mplier  input  N_REQ*WIDTH  packed multipliers; slice i belongs to requester i.
REQ-007 req_mpcand  input  N_REQ*WIDTH  packed multiplicands; slice i belongs to requester i.
REQ-008 req_ready  output  N_REQ  one-hot accept pulse.
REQ-009 rsp_valid  output  N_REQ  one-hot result-valid pulse.
REQ-010 rsp_product  output  2*WIDTH  signed product; valid when any rsp_valid bit is high.
REQ-011 mul_start  output  1  start strobe to the shared Booth multiplier.
REQ-012 mul_mplier, mul_mpcand  output  WIDTH each  operands to the multiplier; held stable from LAUNCH through WAIT.
REQ-013 mul_done  input  1  multiplier Done flag; level; stale-high until the multiplier samples start.
REQ-014 mul_product  input  2*WIDTH  multiplier result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  2  index of the current or last granted requester.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT, RESP, with one-cycle LAUNCH and RESP.
REQ-018 IDLE: if any req_valid is high, select a winner round-robin, pulse req_ready[winner] for one cycle, latch its operands and id, then go to LAUNCH; otherwise stay in IDLE.
REQ-019 Round-robin priority starts at (last_grant+1) mod 4 and searches upward with wrap; after reset last_grant=3, so requester 0 has priority.
REQ-020 LAUNCH: mul_start=1 for exactly one cycle with latched operands; next state WAIT.
REQ-021 WAIT: mul_done is ignored in the first WAIT cycle (masks the stale Done); from the second cycle on, mul_done=1 captures mul_product and moves to RESP.
REQ-022 RESP: rsp_valid[grant_id]=1 for one cycle with rsp_product held; next state IDLE.
REQ-023 Latency: req_ready to rsp_valid is mul latency + 3 cycles; 12 cycles with the 16-bit radix-4 multiplier (8 iterations + 1 load).
REQ-024 A requester deasserting req_valid after acceptance has no effect; the operation completes and responds.
REQ-025 Requests arriving in any state other than IDLE are not accepted until the FSM returns to IDLE; there is no queueing.
REQ-026 req_ready and rsp_valid are never both high for the same requester in the same cycle; at most one bit of each is high.
REQ-027 rsp_product keeps its last value until the next RESP.

Reset
REQ-028 On Reset_n=0, at any point including mid-operation: state=IDLE, busy=0, mul_start=0, req_ready=0, rsp_valid=0, rsp_product=0, mul_mplier=0, mul_mpcand=0, grant_id=3, last_grant=3.
REQ-029 An operation aborted by reset produces no response; the requester must re-request.

Configuration
REQ-030 Macro ARB_WATCHDOG_EN compiles in a 5-bit WAIT timeout counter and output timeout_err (1 bit).
REQ-031 With ARB_WATCHDOG_EN: if WAIT lasts 31 cycles without an accepted mul_done, go to RESP with rsp_product=0 and pulse timeout_err for one cycle coincident with rsp_valid.
REQ-032 Without ARB_WATCHDOG_EN: timeout_err is absent and WAIT waits indefinitely.

Verification
REQ-033 Single request: req_valid=0001, mplier=3, mpcand=-5 -> req_ready=0001, then 12 cycles later rsp_valid=0001 with rsp_product=-15 (0xFFFFFFF1).
REQ-034 Contention: req_valid=1111 held -> grant order 0,1,2,3,0; each rsp_valid matches the granted index and product.
REQ-035 Stale Done: mul_done held high through LAUNCH and the first WAIT cycle -> no RESP until mul_done is seen again from the second WAIT cycle.
REQ-036 Extremes: mplier=0x8000, mpcand=0x8000 -> 0x40000000; mplier=0x7FFF, mpcand=0x8000 -> 0xC0008000.
REQ-037 Reset in WAIT: Reset_n low for 2 cycles -> all outputs at reset values, no rsp_valid; the next request is granted to requester 0.
REQ-038 Watchdog (ARB_WATCHDOG_EN defined, mul_done tied 0) -> after 31 WAIT cycles, rsp_valid and timeout_err pulse together with rsp_product=0.
